// File: rtl/m_dm_ctrl_if.sv
// Bundle of the M-stage pipeline controls and the data-memory request/ready bus
// seen by m_dm_ctrl (slave view) and its environment (master view).
interface m_dm_ctrl_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        m_data_req;
  logic        m_data_ready;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic [31:0] DMRaw;
  logic        Stall;
  logic        AdEL;
  logic        AdES;

  modport slave (
    input  MemRead, MemWrite, Size, Addr, WD, m_data_ready, m_data_rdata,
    output m_data_req, m_data_addr, m_data_wdata, m_data_byteen, DMRaw, Stall, AdEL, AdES
  );

  modport master (
    output MemRead, MemWrite, Size, Addr, WD, m_data_ready, m_data_rdata,
    input  m_data_req, m_data_addr, m_data_wdata, m_data_byteen, DMRaw, Stall, AdEL, AdES
  );
endinterface

// File: rtl/m_dm_ctrl.sv
// M-stage data-memory access controller: one outstanding request, pipeline stall until ready.
// Optional alignment trap (AdEL/AdES) is built in when ALIGN_CHECK_EN is defined.
//
// state | meaning
// IDLE  | no request; an access latches the request registers and stalls
// BUSY  | request held on the bus until m_data_ready
// DONE  | request finished, stall released so the pipeline advances
module m_dm_ctrl (
  input  logic        clk,
  input  logic        reset,
  m_dm_ctrl_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_byteen;
  logic        r_read;
  logic [31:0] r_dmraw;

  logic        w_access;
  logic        w_is_store;
  logic        w_misaligned;
  logic        w_idle;
  logic        w_busy;
  logic        w_start;
  logic [3:0]  w_byteen_st;
  logic [31:0] w_wdata;

  assign w_access   = bus.MemRead | bus.MemWrite;
  assign w_is_store = bus.MemWrite;
  assign w_idle     = (r_state == S_IDLE);
  assign w_busy     = (r_state == S_BUSY);

`ifdef ALIGN_CHECK_EN
  assign w_misaligned = ((bus.Size == 2'd1) & bus.Addr[0]) |
                        (bus.Size[1] & (|bus.Addr[1:0]));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_start = w_idle & w_access & ~w_misaligned;

  always_comb begin
    w_byteen_st = 4'b1111;
    w_wdata     = bus.WD;
    case (bus.Size)
      2'd0: begin
        w_byteen_st = 4'b0001 << bus.Addr[1:0];
        w_wdata     = {4{bus.WD[7:0]}};
      end
      2'd1: begin
        w_byteen_st = bus.Addr[1] ? 4'b1100 : 4'b0011;
        w_wdata     = {2{bus.WD[15:0]}};
      end
      default: begin
        w_byteen_st = 4'b1111;
        w_wdata     = bus.WD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_byteen <= 4'd0;
      r_read   <= 1'b0;
      r_dmraw  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr   <= {bus.Addr[31:2], 2'b00};
            r_wdata  <= w_wdata;
            r_byteen <= w_is_store ? w_byteen_st : 4'b0000;
            r_read   <= ~w_is_store;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.m_data_ready) begin
            if (r_read) r_dmraw <= bus.m_data_rdata;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs are only meaningful while the request is outstanding.
  assign bus.m_data_req    = w_busy;
  assign bus.m_data_addr   = w_busy ? r_addr   : 32'd0;
  assign bus.m_data_wdata  = w_busy ? r_wdata  : 32'd0;
  assign bus.m_data_byteen = w_busy ? r_byteen : 4'd0;
  assign bus.DMRaw         = r_dmraw;
  assign bus.Stall         = ~reset & (w_start | w_busy);

`ifdef ALIGN_CHECK_EN
  assign bus.AdEL = ~reset & w_idle & w_access & w_misaligned & ~w_is_store;
  assign bus.AdES = ~reset & w_idle & w_access & w_misaligned & w_is_store;
`else
  assign bus.AdEL = 1'b0;
  assign bus.AdES = 1'b0;
`endif
endmodule

// File: tb/tb_m_dm_ctrl.sv
// Scoreboard bench for m_dm_ctrl: driver pushes expected requests, monitor pops on req&ready,
// memory model answers with random latency. Honours ALIGN_CHECK_EN when defined.
module tb_m_dm_ctrl;
  logic clk;
  logic reset;
  m_dm_ctrl_if bus ();

  m_dm_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic        load;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] exp_dmraw;
  int          n_cmp;
  int          n_err;

  int          force_waits;
  logic        force_rd;
  logic [31:0] force_rdata;
  int          last_waits;
  logic        in_txn;
  int          wcnt;
  int          waits;
  logic [31:0] last_addr;
  logic [3:0]  last_byteen;
  logic [31:0] last_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: lanes and replication derived from access width in bytes.
  function automatic req_t model(input logic rd, input logic wr, input logic [1:0] sz,
                                 input logic [31:0] a, input logic [31:0] d);
    req_t r;
    int nb, off;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = (nb == 4) ? 0 : ((a % 4) / nb) * nb;
    r.addr = a & 32'hFFFF_FFFC;
    r.load = rd && !wr;
    r.byteen = r.load ? 4'd0 : 4'(((1 << nb) - 1) << off);
    r.wdata = 32'd0;
    for (int i = 0; i < 4; i++) r.wdata[i*8 +: 8] = d[(i % nb)*8 +: 8];
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef ALIGN_CHECK_EN
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one M-stage instruction at posedge+1 and hold it until the pipeline advances.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    logic acc, mis, go, done;
    int cyc, exp_cyc;
    acc = rd | wr;
    mis = acc && misaligned(sz, a);
    go  = acc && !mis;
    bus.MemRead = rd; bus.MemWrite = wr; bus.Size = sz; bus.Addr = a; bus.WD = d;
    if (go) exp_q.push_back(model(rd, wr, sz, a, d));
    cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("AdEL", {31'd0, bus.AdEL}, {31'd0, mis && !wr});
        chk("AdES", {31'd0, bus.AdES}, {31'd0, mis && wr});
        chk("stall_first", {31'd0, bus.Stall}, {31'd0, go});
      end
      if (!bus.Stall) done = 1'b1;
    end
    if (!done) chk("stall_timeout", 32'd1, 32'd0);
    exp_cyc = go ? 3 + last_waits : 1;
    chk("occupancy", cyc, exp_cyc);
    @(posedge clk); #1;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
  endtask

  // Memory: variable latency, random read data on every cycle.
  initial begin
    bus.m_data_ready = 1'b0;
    bus.m_data_rdata = 32'd0;
    in_txn = 1'b0;
    wcnt = 0;
    waits = 0;
    forever begin
      @(posedge clk); #2;
      if (reset || !bus.m_data_req) begin
        bus.m_data_ready = 1'b0;
        bus.m_data_rdata = $urandom;
        in_txn = 1'b0;
      end else begin
        if (!in_txn) begin
          in_txn = 1'b1;
          wcnt = 0;
          waits = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
          last_waits = waits;
        end
        if (wcnt == waits) begin
          bus.m_data_ready = 1'b1;
          bus.m_data_rdata = force_rd ? force_rdata : $urandom;
        end else begin
          bus.m_data_ready = 1'b0;
          bus.m_data_rdata = $urandom;
        end
        wcnt++;
      end
    end
  end

  // Monitor: compares the held request every BUSY cycle, retires it on ready.
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (reset) continue;
      chk("dmraw", bus.DMRaw, exp_dmraw);
      if (bus.m_data_req) begin
        if (exp_q.size() == 0) begin
          chk("req_unexpected", {31'd0, bus.m_data_req}, 32'd0);
        end else begin
          e = exp_q[0];
          chk("req_addr", bus.m_data_addr, e.addr);
          chk("req_byteen", {28'd0, bus.m_data_byteen}, {28'd0, e.byteen});
          if (!e.load) chk("req_wdata", bus.m_data_wdata, e.wdata);
          if (bus.m_data_ready) begin
            void'(exp_q.pop_front());
            last_addr = bus.m_data_addr;
            last_byteen = bus.m_data_byteen;
            last_wdata = bus.m_data_wdata;
            if (e.load) exp_dmraw = bus.m_data_rdata;
          end
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0;
    exp_dmraw = 32'd0;
    force_waits = -1; force_rd = 1'b0; force_rdata = 32'd0; last_waits = 0;
    last_addr = 32'd0; last_byteen = 4'd0; last_wdata = 32'd0;
    bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.Size = 2'd2;
    bus.Addr = 32'h0000_0010; bus.WD = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_req", {31'd0, bus.m_data_req}, 32'd0);
    chk("rst_stall", {31'd0, bus.Stall}, 32'd0);
    chk("rst_addr", bus.m_data_addr, 32'd0);
    chk("rst_dmraw", bus.DMRaw, 32'd0);
    bus.MemRead = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Load word, ready in first BUSY cycle.
    force_waits = 0; force_rd = 1'b1; force_rdata = 32'hDEAD_BEEF;
    issue(1'b1, 1'b0, 2'd2, 32'h0000_0104, 32'h0);
    chk("lw_addr", last_addr, 32'h0000_0104);
    chk("lw_byteen", {28'd0, last_byteen}, 32'd0);
    chk("lw_dmraw", bus.DMRaw, 32'hDEAD_BEEF);

    // Store byte with 3 wait cycles.
    force_waits = 3;
    issue(1'b0, 1'b1, 2'd0, 32'h0000_0203, 32'h1234_5678);
    chk("sb_byteen", {28'd0, last_byteen}, 32'h8);
    chk("sb_wdata", last_wdata, 32'h7878_7878);
    chk("sb_dmraw_kept", bus.DMRaw, 32'hDEAD_BEEF);

    // Store half upper lane.
    force_waits = 1;
    issue(1'b0, 1'b1, 2'd1, 32'h0000_0042, 32'hAAAA_5555);
    chk("sh_byteen", {28'd0, last_byteen}, 32'hC);
    chk("sh_wdata", last_wdata, 32'h5555_5555);
    chk("sh_addr", last_addr, 32'h0000_0040);

    // Two consecutive loads.
    force_waits = 0; force_rdata = 32'h1111_2222;
    issue(1'b1, 1'b0, 2'd2, 32'h0000_0400, 32'h0);
    chk("ld1_dmraw", bus.DMRaw, 32'h1111_2222);
    force_rdata = 32'h3333_4444;
    issue(1'b1, 1'b0, 2'd2, 32'h0000_0404, 32'h0);
    chk("ld2_dmraw", bus.DMRaw, 32'h3333_4444);

    // Reset while BUSY.
    force_waits = 6; force_rd = 1'b0;
    bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.Size = 2'd2; bus.Addr = 32'h0000_0300;
    exp_q.push_back(model(1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'h0));
    @(posedge clk); #3;
    chk("busy_req", {31'd0, bus.m_data_req}, 32'd1);
    chk("busy_stall", {31'd0, bus.Stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_req", {31'd0, bus.m_data_req}, 32'd0);
    chk("arst_stall", {31'd0, bus.Stall}, 32'd0);
    chk("arst_addr", bus.m_data_addr, 32'd0);
    chk("arst_wdata", bus.m_data_wdata, 32'd0);
    chk("arst_byteen", {28'd0, bus.m_data_byteen}, 32'd0);
    chk("arst_dmraw", bus.DMRaw, 32'd0);
    chk("arst_ade", {30'd0, bus.AdEL, bus.AdES}, 32'd0);
    exp_q.delete();
    exp_dmraw = 32'd0;
    bus.MemRead = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    force_waits = -1;
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 2'd2, 32'h0000_0500, 32'h0);
    chk("post_rst_addr", last_addr, 32'h0000_0500);

    // Misaligned word load.
    force_waits = 0;
    issue(1'b1, 1'b0, 2'd2, 32'h0000_0102, 32'h0);
`ifndef ALIGN_CHECK_EN
    chk("mis_addr", last_addr, 32'h0000_0100);
`endif

    // Random instruction stream.
    force_waits = -1;
    for (int i = 0; i < 200; i++) begin
      logic [1:0] kind;
      logic [31:0] a;
      kind = 2'($urandom_range(0, 3));
      a = $urandom;
      issue(kind[0], kind[1], 2'($urandom_range(0, 3)), a, $urandom);
    end

    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
